// File: rtl/playbus_pkg.sv
// Shared PlayBus definitions: default widths, fixed ROM contents
// and the controller's function codes.
package playbus_pkg;

    localparam int AW_DEF = 4;
    localparam int DW_DEF = 8;

    // Controller function list (FUNC 0-7)
    localparam logic [2:0] FUNC_IDLE    = 3'd0;
    localparam logic [2:0] FUNC_ROM_LED = 3'd1;
    localparam logic [2:0] FUNC_RAM_LED = 3'd2;
    localparam logic [2:0] FUNC_SW_RAM  = 3'd3;
    localparam logic [2:0] FUNC_ROM_RAM = 3'd4;
    localparam logic [2:0] FUNC_SW_LED  = 3'd5;
    localparam logic [2:0] FUNC_RAM_RD  = 3'd6;
    localparam logic [2:0] FUNC_CLEAR   = 3'd7;

    // ROM[a] = a * 17, so a 4-bit address yields 0x00, 0x11 ... 0xFF
    function automatic logic [DW_DEF-1:0] rom_data(input int unsigned addr);
        int unsigned p;
        p = addr * 32'd17;
        return p[DW_DEF-1:0];
    endfunction

endpackage

// File: rtl/playbus_ram16.sv
// PlayBus RAM: 2**AW x DW register file, one synchronous write port,
// one combinational read port, cleared by asynchronous rst.
//   clk, rst        : clock, async active-high clear
//   we, waddr, wdata: write port
//   raddr, rdata    : combinational read port
import playbus_pkg::*;

module playbus_ram16 #(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/playbus_target.sv
// PlayBus responder: ROM, RAM, switch buffer and LED latch behind the
// controller's strobes, with write counter and sticky protocol flags.
//   CK2HZ, CLR               : clock, async active-high reset
//   ADD, n_ROMO/n_RAMO/n_SWBEN: address and active-low source enables
//   n_RAMW, LEDLTCH          : RAM write strobe (low), LED latch (high)
//   SW, DATA_IN              : switches, resolved bus value
//   DATA_OUT, DATA_OE        : bus drive value and enable
//   LED, WRCNT               : LED latch, RAM write count
//   CONTEND, WRERR           : sticky multi-source / no-source flags
import playbus_pkg::*;

module playbus_target #(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          CK2HZ,
    input  logic          CLR,
    input  logic [AW-1:0] ADD,
    input  logic          n_ROMO,
    input  logic          n_RAMO,
    input  logic          n_SWBEN,
    input  logic          n_RAMW,
    input  logic          LEDLTCH,
    input  logic [DW-1:0] SW,
    input  logic [DW-1:0] DATA_IN,
    output logic [DW-1:0] DATA_OUT,
    output logic          DATA_OE,
    output logic [DW-1:0] LED,
    output logic [7:0]    WRCNT,
    output logic          CONTEND,
    output logic          WRERR
);

    logic          prev_ramw_q, prev_ramw_d;
    logic          prev_led_q, prev_led_d;
    logic [DW-1:0] led_q, led_d;
    logic [7:0]    wrcnt_q, wrcnt_d;
    logic          contend_q, contend_d;
    logic          wrerr_q, wrerr_d;

    logic [1:0]    n_act;
    logic          src_none;
    logic          src_one;
    logic          src_multi;
    logic          ram_we;
    logic          led_edge;
    logic [DW-1:0] ram_rdata;
    logic [DW-1:0] rom_rdata;
    logic [DW-1:0] data_out;
    logic          data_oe;

    playbus_ram16 #(
        .AW (AW),
        .DW (DW)
    ) u_ram (
        .clk   (CK2HZ),
        .rst   (CLR),
        .we    (ram_we),
        .waddr (ADD),
        .wdata (DATA_IN),
        .raddr (ADD),
        .rdata (ram_rdata)
    );

    assign rom_rdata = DW'(rom_data(32'(ADD)));

    always_comb begin
        n_act = {1'b0, ~n_ROMO} + {1'b0, ~n_RAMO} + {1'b0, ~n_SWBEN};
        src_none  = (n_act == 2'd0);
        src_one   = (n_act == 2'd1);
        src_multi = (n_act >= 2'd2);
    end

    // Drive the bus only when exactly one source is selected
    always_comb begin
        data_out = '0;
        data_oe  = 1'b0;
        if (src_one) begin
            data_oe = 1'b1;
            unique case (1'b1)
                !n_ROMO: data_out = rom_rdata;
                !n_RAMO: data_out = ram_rdata;
                default: data_out = SW;
            endcase
        end
    end

    always_comb begin
        ram_we     = !n_RAMW && prev_ramw_q;
        led_edge   = LEDLTCH && !prev_led_q;
        prev_ramw_d = n_RAMW;
        prev_led_d  = LEDLTCH;
        led_d      = led_edge ? DATA_IN : led_q;
        wrcnt_d    = wrcnt_q + 8'(ram_we);
        contend_d  = contend_q | src_multi;
        // The capture itself still happens; only the flag records it
        wrerr_d    = wrerr_q | ((ram_we | led_edge) & src_none);
    end

    always_ff @(posedge CK2HZ or posedge CLR) begin
        if (CLR) begin
            prev_ramw_q <= 1'b1;
            prev_led_q  <= 1'b0;
            led_q       <= '0;
            wrcnt_q     <= '0;
            contend_q   <= 1'b0;
            wrerr_q     <= 1'b0;
        end else begin
            prev_ramw_q <= prev_ramw_d;
            prev_led_q  <= prev_led_d;
            led_q       <= led_d;
            wrcnt_q     <= wrcnt_d;
            contend_q   <= contend_d;
            wrerr_q     <= wrerr_d;
        end
    end

    assign DATA_OUT = data_out;
    assign DATA_OE  = data_oe;
    assign LED      = led_q;
    assign WRCNT    = wrcnt_q;
    assign CONTEND  = contend_q;
    assign WRERR    = wrerr_q;

endmodule

// File: tb/tb_playbus_target.sv
// Self-checking bench for playbus_target: vector table for source
// select, scoreboard queue for strobe/flag/counter sequences.
module tb_playbus_target;

    logic       clk = 1'b0;
    logic       clr;
    logic [3:0] add;
    logic       n_romo, n_ramo, n_swben, n_ramw, ledltch;
    logic [7:0] sw, ext, data_in, data_out, led, wrcnt;
    logic       data_oe, contend, wrerr;

    localparam int S_OUT = 0, S_OE = 1, S_LED = 2;
    localparam int S_CNT = 3, S_CON = 4, S_ERR = 5;

    typedef struct {
        int         sig;
        logic [7:0] exp;
        string      tag;
    } sb_t;

    typedef struct {
        logic [3:0] add;
        logic       n_romo;
        logic       n_ramo;
        logic       n_swben;
        logic [7:0] sw;
        logic       oe;
        logic [7:0] out;
    } vec_t;

    sb_t  sbq[$];
    vec_t vecs[9];
    int   n_checks = 0;
    int   n_fail   = 0;

    assign data_in = data_oe ? data_out : ext;

    always #5 clk = ~clk;

    playbus_target dut (
        .CK2HZ    (clk),
        .CLR      (clr),
        .ADD      (add),
        .n_ROMO   (n_romo),
        .n_RAMO   (n_ramo),
        .n_SWBEN  (n_swben),
        .n_RAMW   (n_ramw),
        .LEDLTCH  (ledltch),
        .SW       (sw),
        .DATA_IN  (data_in),
        .DATA_OUT (data_out),
        .DATA_OE  (data_oe),
        .LED      (led),
        .WRCNT    (wrcnt),
        .CONTEND  (contend),
        .WRERR    (wrerr)
    );

    function automatic logic [7:0] obs(input int sig);
        case (sig)
            S_OUT:   return data_out;
            S_OE:    return {7'd0, data_oe};
            S_LED:   return led;
            S_CNT:   return wrcnt;
            S_CON:   return {7'd0, contend};
            default: return {7'd0, wrerr};
        endcase
    endfunction

    task automatic push(input int sig, input logic [7:0] e, input string tag);
        sbq.push_back('{sig, e, tag});
    endtask

    task automatic drain();
        sb_t s;
        logic [7:0] got;
        while (sbq.size() > 0) begin
            s = sbq.pop_front();
            got = obs(s.sig);
            n_checks++;
            if (got !== s.exp) begin
                n_fail++;
                $display("FAIL %s: got %h, expected %h", s.tag, got, s.exp);
            end
        end
    endtask

    task automatic idle();
        n_romo  = 1'b1;
        n_ramo  = 1'b1;
        n_swben = 1'b1;
        n_ramw  = 1'b1;
        ledltch = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{4'h0, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00};
        vecs[1] = '{4'h5, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 8'h55};
        vecs[2] = '{4'hF, 1'b0, 1'b1, 1'b1, 8'h12, 1'b1, 8'hFF};
        vecs[3] = '{4'h1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 8'h11};
        vecs[4] = '{4'h7, 1'b1, 1'b0, 1'b1, 8'hC3, 1'b1, 8'h00};
        vecs[5] = '{4'h2, 1'b1, 1'b1, 1'b0, 8'h5A, 1'b1, 8'h5A};
        vecs[6] = '{4'hA, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b0, 8'h00};
        vecs[7] = '{4'h4, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0, 8'h00};
        vecs[8] = '{4'h6, 1'b1, 1'b0, 1'b0, 8'h99, 1'b0, 8'h00};

        clr = 1'b1;
        idle();
        add = '0;
        sw  = '0;
        ext = '0;
        #2;

        // Source select is combinational, so sweep it while held in reset
        for (int i = 0; i < 9; i++) begin
            add     = vecs[i].add;
            n_romo  = vecs[i].n_romo;
            n_ramo  = vecs[i].n_ramo;
            n_swben = vecs[i].n_swben;
            sw      = vecs[i].sw;
            #1;
            push(S_OE, {7'd0, vecs[i].oe}, $sformatf("vec%0d_oe", i));
            push(S_OUT, vecs[i].out, $sformatf("vec%0d_out", i));
            drain();
        end

        idle();
        push(S_LED, 8'h00, "rst_led");
        push(S_CNT, 8'h00, "rst_wrcnt");
        push(S_CON, 8'h00, "rst_contend");
        push(S_ERR, 8'h00, "rst_wrerr");
        drain();
        step();
        clr = 1'b0;
        step();

        // ROM read
        add = 4'd5;
        n_romo = 1'b0;
        #1;
        push(S_OE, 8'h01, "rom_oe");
        push(S_OUT, 8'h55, "rom_out");
        drain();
        n_romo = 1'b1;
        #1;
        push(S_OE, 8'h00, "rom_release_oe");
        drain();

        // Switch to RAM, strobe held low for three edges
        sw = 8'hA7;
        add = 4'd9;
        n_swben = 1'b0;
        n_ramw = 1'b0;
        step();
        push(S_CNT, 8'h01, "sw_ram_first_edge");
        drain();
        step();
        step();
        n_ramw = 1'b1;
        push(S_CNT, 8'h01, "sw_ram_held_once");
        push(S_ERR, 8'h00, "sw_ram_wrerr");
        drain();
        n_swben = 1'b1;
        n_ramo = 1'b0;
        #1;
        push(S_OUT, 8'hA7, "ram9_readback");
        drain();
        n_ramo = 1'b1;
        step();

        // ROM to LED, latch held high across an address change
        add = 4'd3;
        n_romo = 1'b0;
        ledltch = 1'b1;
        step();
        push(S_LED, 8'h33, "rom_led");
        drain();
        add = 4'd4;
        step();
        push(S_LED, 8'h33, "led_held_once");
        ledltch = 1'b0;
        n_romo = 1'b1;
        push(S_ERR, 8'h00, "rom_led_wrerr");
        push(S_CON, 8'h00, "rom_led_contend");
        drain();

        // Write strobe with no source enabled
        ext = 8'h3C;
        add = 4'd0;
        n_ramw = 1'b0;
        step();
        n_ramw = 1'b1;
        push(S_ERR, 8'h01, "nosrc_wrerr");
        push(S_CNT, 8'h02, "nosrc_wrcnt");
        push(S_CON, 8'h00, "nosrc_contend");
        drain();
        n_ramo = 1'b0;
        #1;
        push(S_OUT, 8'h3C, "ram0_readback");
        drain();
        n_ramo = 1'b1;
        step();

        // Contention
        n_romo = 1'b0;
        n_swben = 1'b0;
        #1;
        push(S_OE, 8'h00, "contend_oe");
        push(S_OUT, 8'h00, "contend_out");
        push(S_CON, 8'h00, "contend_before_edge");
        drain();
        step();
        push(S_CON, 8'h01, "contend_set");
        drain();
        n_romo = 1'b1;
        n_swben = 1'b1;
        step();
        push(S_CON, 8'h01, "contend_sticky");
        drain();

        // Counter wrap: 2 + 253 = 255, then one more wraps to 0
        repeat (253) begin
            n_ramw = 1'b0;
            step();
            n_ramw = 1'b1;
            step();
        end
        push(S_CNT, 8'hFF, "wrcnt_255");
        drain();
        n_ramw = 1'b0;
        step();
        n_ramw = 1'b1;
        push(S_CNT, 8'h00, "wrcnt_wrap");
        drain();
        step();

        // CLR mid-pulse, strobes still active on release
        ext = 8'h81;
        add = 4'd9;
        ledltch = 1'b1;
        n_ramw = 1'b0;
        step();
        push(S_LED, 8'h81, "pre_clr_led");
        drain();
        #2;
        clr = 1'b1;
        #1;
        push(S_LED, 8'h00, "clr_led");
        push(S_CNT, 8'h00, "clr_wrcnt");
        push(S_CON, 8'h00, "clr_contend");
        push(S_ERR, 8'h00, "clr_wrerr");
        drain();
        n_ramo = 1'b0;
        #1;
        push(S_OUT, 8'h00, "clr_ram9");
        drain();
        n_ramo = 1'b1;
        #1;
        clr = 1'b0;
        step();
        push(S_CNT, 8'h01, "post_clr_wrcnt");
        push(S_LED, 8'h81, "post_clr_led");
        drain();
        n_ramw = 1'b1;
        ledltch = 1'b0;
        n_ramo = 1'b0;
        #1;
        push(S_OUT, 8'h81, "post_clr_ram9");
        drain();
        idle();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/playbus_target.md
# playbus_target

Responder side of the PlayBus: models the ROM, 16×8 RAM, switch buffer and LED latch that the PlayBus controller strobes. Decodes the controller's active-low output enables and write strobes. Drives the shared data bus from the selected source, captures bus data into RAM or LEDs on strobe edges, and flags protocol violations. Clocked on the same CK2HZ as the controller, so every strobe is seen as a clean registered level.

## Interface
- AW, 4: address width; RAM depth is 2**AW.
- DW, 8: data bus width.
- CK2HZ  in  1  system clock, shared with the controller.
- CLR  in  1  asynchronous active-high reset.
- ADD  in  AW  bus address.
- n_ROMO  in  1  ROM output enable, active low.
- n_RAMO  in  1  RAM output enable, active low.
- n_SWBEN  in  1  switch buffer enable, active low.
- n_RAMW  in  1  RAM write strobe, active low.
- LEDLTCH  in  1  LED latch strobe, active high.
- SW  in  DW  switch inputs.
- DATA_IN  in  DW  resolved bus value. The bench or top level forms it as DATA_OE ? DATA_OUT : external driver.
- DATA_OUT  out  DW  value this block drives onto the bus.
- DATA_OE  out  1  bus drive enable.
- LED  out  DW  LED latch contents.
- WRCNT  out  8  count of RAM writes.
- CONTEND  out  1  sticky flag: more than one source enabled.
- WRERR  out  1  sticky flag: write strobe with no source enabled.

## Operation
- Source select is combinational. Count the active enables: n_ROMO low, n_RAMO low, n_SWBEN low.
  - Exactly one active: DATA_OE = 1, and DATA_OUT = ROM[ADD], RAM[ADD] or SW respectively.
  - Zero or two or more active: DATA_OE = 0, DATA_OUT = 0.
- ROM contents are fixed: ROM[a] = a × 17 (0x00, 0x11, … 0xFF).
- Edge detection uses registers prev_ramw (resets to 1) and prev_led (resets to 0).
- RAM write: on a posedge where n_RAMW = 0 and prev_ramw = 1, RAM[ADD] <= DATA_IN and WRCNT increments.
  - WRCNT wraps 255 → 0.
  - n_RAMW held low for several cycles writes only once.
- LED latch: on a posedge where LEDLTCH = 1 and prev_led = 0, LED <= DATA_IN. Holding LEDLTCH high latches once.
- CONTEND: set at any posedge where two or more enables are sampled active. Cleared only by CLR.
- WRERR: set at any write or latch edge (as defined above) where no enable is active. The write/latch still occurs with DATA_IN.
- Simultaneous RAM write edge and n_RAMO low at the same ADD: DATA_OUT shows the old RAM value until the edge and the new value after it.
- Simultaneous RAM write edge and LED latch edge: both capture the same DATA_IN.

## Timing
- Reset values: RAM all 0x00, LED = 0, WRCNT = 0, CONTEND = 0, WRERR = 0, prev_ramw = 1, prev_led = 0.
- DATA_OUT and DATA_OE have zero-cycle (combinational) latency from the enables, ADD and SW.
- RAM, LED and WRCNT update at the sampling edge. They are visible immediately after it, with 1-cycle latency relative to the strobe assertion.
- Controller sequence FUNC 3/4: the controller raises RAMW one cycle after entering start_source.
  - The responder sees n_RAMW low at the edge leaving do_write.
  - The source is still enabled at that edge, so the write data is valid.
- CLR asserted mid-transfer clears everything immediately and asynchronously.
  - A strobe still active at the first edge after CLR deasserts is treated as a new edge and performs a write/latch.

## Structure
- Package playbus_pkg holds:
  - AW and DW defaults.
  - Function rom_data(addr) returning addr × 17, truncated to DW.
  - FUNC code constants 0–7 matching the controller's function list.
- Sub-module playbus_ram16: 2**AW × DW register file. One write port (clk, we, waddr, wdata) and one combinational read port. Cleared by CLR.
- The top level holds source mux, edge detectors, counter and flags.

## Test plan
- ROM read: ADD = 5, n_ROMO = 0, others inactive → DATA_OE = 1, DATA_OUT = 0x55. Then n_ROMO = 1 → DATA_OE = 0.
- Switch-to-RAM: SW = 0xA7, n_SWBEN = 0, n_RAMW low for 3 cycles at ADD = 9, DATA_IN = DATA_OUT.
  - Expect RAM[9] = 0xA7 and WRCNT = 1 (not 3).
  - Then n_RAMO = 0 at ADD = 9 → DATA_OUT = 0xA7.
- ROM-to-LED: ADD = 3, n_ROMO = 0, LEDLTCH pulses high → LED = 0x33, WRERR = 0, CONTEND = 0.
- Contention: n_ROMO = 0 and n_SWBEN = 0 together → DATA_OE = 0 combinationally, CONTEND = 1 after next edge and stays 1 after enables release.
- Strobe with no source: n_RAMW pulse, all enables high, DATA_IN = 0x3C, ADD = 0 → RAM[0] = 0x3C, WRERR = 1.
- Wrap and reset: 256 separate n_RAMW pulses → WRCNT = 0. Then CLR mid-pulse → all outputs at reset values; first edge after release with n_RAMW still low → WRCNT = 1.
